dtls_only_tx_64: RTL and testbench

DTLS_ONLY_TX_64 -- requirements
Module: dtls_only_tx_64

---
 rtl/dtls_only_tx_64.sv | 244 ++++++++++++++++++++++++
 tb/tb_dtls_only_tx_64.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dtls_only_tx_64.sv
// DTLS record transmitter, 64-bit datapath.
// Prepends the 13-byte DTLS record header (type, version, epoch, 48-bit
// sequence number, length) to a payload stream. Because 13 = 8 + 5, every
// payload beat after the first header beat is shifted by five byte lanes.
// A 40-bit residual register carries the top five bytes of each input beat
// into the next output beat. The residual is preloaded with the last five
// header bytes, so header beat 1 and all later payload beats use one path.
module dtls_only_tx_64 (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        s_dtls_hdr_valid,
    output logic        s_dtls_hdr_ready,
    input  logic [7:0]  s_dtls_type,
    input  logic [15:0] s_dtls_version,
    input  logic [15:0] s_dtls_epoch,
    input  logic [47:0] s_dtls_seqnum,
    input  logic [15:0] s_dtls_length,

    input  logic [63:0] s_dtls_payload_axis_tdata,
    input  logic [7:0]  s_dtls_payload_axis_tkeep,
    input  logic        s_dtls_payload_axis_tvalid,
    output logic        s_dtls_payload_axis_tready,
    input  logic        s_dtls_payload_axis_tlast,
    input  logic        s_dtls_payload_axis_tuser,

    output logic [63:0] m_axis_tdata,
    output logic [7:0]  m_axis_tkeep,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tlast,
    output logic        m_axis_tuser,

    output logic        busy,
    output logic        error_payload_early_termination
);

    typedef enum logic [1:0] {
        IDLE          = 2'd0,
        WRITE_HEADER  = 2'd1,
        WRITE_PAYLOAD = 2'd2,
        WRITE_TAIL    = 2'd3
    } state_t;

    state_t      state_reg;
    logic [63:0] m_data_reg;
    logic [7:0]  m_keep_reg;
    logic        m_valid_reg;
    logic        m_last_reg;
    logic        m_user_reg;
    logic [39:0] residual_reg;
    logic [15:0] count_reg;
    logic [15:0] length_reg;
    logic [7:0]  tail_keep_reg;
    logic        tail_user_reg;
    logic        tail_err_reg;
    logic        busy_reg;
    logic        error_reg;
    logic        hdr_en_reg;

    logic        out_free;
    logic        hdr_fire;
    logic        pay_fire;
    logic        short_last;
    logic [3:0]  in_bytes;
    logic [16:0] count_sum;
    logic [15:0] count_next;
    logic        mismatch;
    logic [7:0]  last_keep;
    logic [7:0]  tail_keep_next;
    logic [7:0]  pay_keep;
    logic [63:0] pay_raw;
    logic [63:0] pay_masked;
    logic [63:0] tail_raw;
    logic [63:0] tail_masked;

    // The output register can take a new beat when it is empty or
    // draining in this cycle.
    assign out_free = !m_valid_reg || m_axis_tready;

    // The header is accepted only in IDLE. hdr_en_reg keeps ready low until
    // the first clock edge after reset is released.
    assign s_dtls_hdr_ready           = hdr_en_reg && (state_reg == IDLE) && out_free;
    assign s_dtls_payload_axis_tready = (state_reg == WRITE_PAYLOAD) && out_free;

    assign hdr_fire = s_dtls_hdr_valid && s_dtls_hdr_ready;
    assign pay_fire = s_dtls_payload_axis_tvalid && s_dtls_payload_axis_tready;

    assign m_axis_tdata  = m_data_reg;
    assign m_axis_tkeep  = m_keep_reg;
    assign m_axis_tvalid = m_valid_reg;
    assign m_axis_tlast  = m_last_reg;
    assign m_axis_tuser  = m_user_reg;
    assign busy          = busy_reg;
    assign error_payload_early_termination = error_reg;

    // Count the valid bytes in the current input beat. tkeep is contiguous
    // from lane 0, so this count equals the beat's byte length.
    always_comb begin
        in_bytes = 4'd0;
        for (int i = 0; i < 8; i++) begin
            in_bytes = in_bytes + {3'd0, s_dtls_payload_axis_tkeep[i]};
        end
    end

    // The running byte count saturates. The mismatch check uses the count
    // that includes the beat being accepted now.
    always_comb begin
        count_sum  = {1'b0, count_reg} + {13'd0, in_bytes};
        count_next = count_sum[16] ? 16'hFFFF : count_sum[15:0];
        mismatch   = (count_next != length_reg);
    end

    // A last beat of at most three bytes fits beside the five residual
    // bytes. Larger last beats leave n-3 bytes for a separate tail beat.
    always_comb begin
        short_last = s_dtls_payload_axis_tlast && (in_bytes <= 4'd3);
        case (in_bytes)
            4'd0:    last_keep = 8'h1F;
            4'd1:    last_keep = 8'h3F;
            4'd2:    last_keep = 8'h7F;
            default: last_keep = 8'hFF;
        endcase
        case (in_bytes)
            4'd4:    tail_keep_next = 8'h01;
            4'd5:    tail_keep_next = 8'h03;
            4'd6:    tail_keep_next = 8'h07;
            4'd7:    tail_keep_next = 8'h0F;
            default: tail_keep_next = 8'h1F;
        endcase
        pay_keep = short_last ? last_keep : 8'hFF;
        pay_raw  = {s_dtls_payload_axis_tdata[23:0], residual_reg};
        tail_raw = {24'h000000, residual_reg};
    end

    // Zero the byte lanes that tkeep marks as unused, so stale residual
    // bytes never appear on the bus.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_lane_mask
            assign pay_masked[gi*8 +: 8]  = pay_keep[gi]      ? pay_raw[gi*8 +: 8]  : 8'h00;
            assign tail_masked[gi*8 +: 8] = tail_keep_reg[gi] ? tail_raw[gi*8 +: 8] : 8'h00;
        end
    endgenerate

    // Control FSM together with the registered output stage and status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            m_data_reg    <= 64'd0;
            m_keep_reg    <= 8'd0;
            m_valid_reg   <= 1'b0;
            m_last_reg    <= 1'b0;
            m_user_reg    <= 1'b0;
            residual_reg  <= 40'd0;
            count_reg     <= 16'd0;
            length_reg    <= 16'd0;
            tail_keep_reg <= 8'd0;
            tail_user_reg <= 1'b0;
            tail_err_reg  <= 1'b0;
            busy_reg      <= 1'b0;
            error_reg     <= 1'b0;
            hdr_en_reg    <= 1'b0;
        end else begin
            hdr_en_reg <= 1'b1;
            error_reg  <= 1'b0;

            // A beat leaves when the sink takes it. A load below overrides this.
            if (m_valid_reg && m_axis_tready) begin
                m_valid_reg <= 1'b0;
            end

            // Busy covers header acceptance through the final beat transfer.
            // A header accepted in the same cycle keeps busy high.
            if (hdr_fire) begin
                busy_reg <= 1'b1;
            end else if (m_valid_reg && m_axis_tready && m_last_reg) begin
                busy_reg <= 1'b0;
            end

            case (state_reg)
                IDLE: begin
                    if (hdr_fire) begin
                        m_data_reg   <= {s_dtls_seqnum[31:24], s_dtls_seqnum[39:32],
                                         s_dtls_seqnum[47:40], s_dtls_epoch[7:0],
                                         s_dtls_epoch[15:8], s_dtls_version[7:0],
                                         s_dtls_version[15:8], s_dtls_type};
                        m_keep_reg   <= 8'hFF;
                        m_valid_reg  <= 1'b1;
                        m_last_reg   <= 1'b0;
                        m_user_reg   <= 1'b0;
                        residual_reg <= {s_dtls_length[7:0], s_dtls_length[15:8],
                                         s_dtls_seqnum[7:0], s_dtls_seqnum[15:8],
                                         s_dtls_seqnum[23:16]};
                        length_reg   <= s_dtls_length;
                        count_reg    <= 16'd0;
                        state_reg    <= WRITE_HEADER;
                    end
                end

                WRITE_HEADER: begin
                    // Header beat 0 is already in the output register.
                    // Header beat 1 goes out with the first payload beat.
                    state_reg <= WRITE_PAYLOAD;
                end

                WRITE_PAYLOAD: begin
                    if (pay_fire) begin
                        m_data_reg   <= pay_masked;
                        m_keep_reg   <= pay_keep;
                        m_valid_reg  <= 1'b1;
                        residual_reg <= s_dtls_payload_axis_tdata[63:24];
                        count_reg    <= count_next;
                        m_last_reg   <= short_last;
                        m_user_reg   <= short_last && (mismatch || s_dtls_payload_axis_tuser);
                        if (short_last) begin
                            error_reg <= mismatch;
                            state_reg <= IDLE;
                        end else if (s_dtls_payload_axis_tlast) begin
                            tail_keep_reg <= tail_keep_next;
                            tail_user_reg <= mismatch || s_dtls_payload_axis_tuser;
                            tail_err_reg  <= mismatch;
                            state_reg     <= WRITE_TAIL;
                        end
                    end
                end

                WRITE_TAIL: begin
                    if (out_free) begin
                        m_data_reg  <= tail_masked;
                        m_keep_reg  <= tail_keep_reg;
                        m_valid_reg <= 1'b1;
                        m_last_reg  <= 1'b1;
                        m_user_reg  <= tail_user_reg;
                        error_reg   <= tail_err_reg;
                        state_reg   <= IDLE;
                    end
                end

                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dtls_only_tx_64.sv
// Directed bench for dtls_only_tx_64. A byte-stream model pushes the
// expected output beats into a queue. A monitor pops the queue and compares
// each beat as the DUT transfers it.
module tb_dtls_only_tx_64;

    logic        clk;
    logic        rst_n;
    logic        hdr_valid;
    logic        hdr_ready;
    logic [7:0]  hdr_type;
    logic [15:0] hdr_version;
    logic [15:0] hdr_epoch;
    logic [47:0] hdr_seqnum;
    logic [15:0] hdr_length;
    logic [63:0] s_tdata;
    logic [7:0]  s_tkeep;
    logic        s_tvalid;
    logic        s_tready;
    logic        s_tlast;
    logic        s_tuser;
    logic [63:0] m_tdata;
    logic [7:0]  m_tkeep;
    logic        m_tvalid;
    logic        m_tready;
    logic        m_tlast;
    logic        m_tuser;
    logic        busy;
    logic        err_pulse;

    typedef struct {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
        logic        user;
    } beat_t;

    beat_t       exp_q[$];
    logic [7:0]  pay [0:63];
    int          tests;
    int          fails;
    int          err_cnt;
    int          tl_done;
    int          hdr_cnt;
    logic        rand_mode;
    logic        tready_fixed;
    logic        prev_hold;
    logic [63:0] hold_data;
    logic [7:0]  hold_keep;
    logic        hold_last;

    dtls_only_tx_64 dut (
        .clk                             (clk),
        .rst_n                           (rst_n),
        .s_dtls_hdr_valid                (hdr_valid),
        .s_dtls_hdr_ready                (hdr_ready),
        .s_dtls_type                     (hdr_type),
        .s_dtls_version                  (hdr_version),
        .s_dtls_epoch                    (hdr_epoch),
        .s_dtls_seqnum                   (hdr_seqnum),
        .s_dtls_length                   (hdr_length),
        .s_dtls_payload_axis_tdata       (s_tdata),
        .s_dtls_payload_axis_tkeep       (s_tkeep),
        .s_dtls_payload_axis_tvalid      (s_tvalid),
        .s_dtls_payload_axis_tready      (s_tready),
        .s_dtls_payload_axis_tlast       (s_tlast),
        .s_dtls_payload_axis_tuser       (s_tuser),
        .m_axis_tdata                    (m_tdata),
        .m_axis_tkeep                    (m_tkeep),
        .m_axis_tvalid                   (m_tvalid),
        .m_axis_tready                   (m_tready),
        .m_axis_tlast                    (m_tlast),
        .m_axis_tuser                    (m_tuser),
        .busy                            (busy),
        .error_payload_early_termination (err_pulse)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] lane_mask(input logic [7:0] keep);
        logic [63:0] m;
        m = 64'd0;
        for (int l = 0; l < 8; l++) begin
            if (keep[l]) m[l*8 +: 8] = 8'hFF;
        end
        return m;
    endfunction

    // Sink tready: held at a fixed level, or about 30% high in random mode.
    initial begin
        m_tready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            m_tready = rand_mode ? ($urandom_range(0, 99) < 30) : tready_fixed;
        end
    end

    // Count final-beat transfers at the clock edge where they happen.
    always @(posedge clk) begin
        if (rst_n && m_tvalid && m_tready && m_tlast) tl_done++;
    end

    // Output monitor: error pulses, stability under backpressure, scoreboard.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_hold = 1'b0;
        end else begin
            if (err_pulse) err_cnt++;
            if (prev_hold) begin
                check("hold_valid", {63'd0, m_tvalid}, 64'd1);
                check("hold_data", m_tdata, hold_data);
                check("hold_keep_last", {55'd0, m_tlast, m_tkeep}, {55'd0, hold_last, hold_keep});
            end
            if (m_tvalid && m_tready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", {56'd0, m_tkeep}, 64'd0);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    check("beat_data", m_tdata & lane_mask(e.keep), e.data);
                    check("beat_keep", {56'd0, m_tkeep}, {56'd0, e.keep});
                    check("beat_last", {63'd0, m_tlast}, {63'd0, e.last});
                    check("beat_user", {63'd0, m_tuser}, {63'd0, e.user});
                end
            end
            prev_hold = m_tvalid && !m_tready;
            hold_data = m_tdata;
            hold_keep = m_tkeep;
            hold_last = m_tlast;
        end
    end

    task automatic send_header(input logic [7:0] typ, input logic [15:0] ver,
                               input logic [15:0] epo, input logic [47:0] seq,
                               input logic [15:0] len, input logic exp_busy);
        bit done;
        done = 0;
        hdr_type    = typ;
        hdr_version = ver;
        hdr_epoch   = epo;
        hdr_seqnum  = seq;
        hdr_length  = len;
        hdr_valid   = 1'b1;
        for (int i = 0; i < 500 && !done; i++) begin
            @(negedge clk);
            if (hdr_ready) begin
                check("no_overlap", 64'(tl_done + int'(m_tvalid && m_tready && m_tlast)), 64'(hdr_cnt));
                check("busy_at_hdr", {63'd0, busy}, {63'd0, exp_busy});
                hdr_cnt++;
                done = 1;
            end
        end
        if (!done) check("hdr_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        hdr_valid = 1'b0;
        if (done) check("hdr_latency", {63'd0, m_tvalid}, 64'd1);
        $display("[TB] header len=%0d accepted=%0d", len, done);
    endtask

    task automatic send_record(input logic [7:0] typ, input logic [15:0] ver,
                               input logic [15:0] epo, input logic [47:0] seq,
                               input logic [15:0] len, input int n,
                               input logic tuser_last, input logic exp_busy);
        logic [7:0] stream [0:127];
        int total;
        int nb;
        stream[0]  = typ;         stream[1]  = ver[15:8];  stream[2]  = ver[7:0];
        stream[3]  = epo[15:8];   stream[4]  = epo[7:0];   stream[5]  = seq[47:40];
        stream[6]  = seq[39:32];  stream[7]  = seq[31:24]; stream[8]  = seq[23:16];
        stream[9]  = seq[15:8];   stream[10] = seq[7:0];   stream[11] = len[15:8];
        stream[12] = len[7:0];
        for (int i = 0; i < n; i++) stream[13 + i] = pay[i];
        total = 13 + n;
        nb = (total + 7) / 8;
        for (int b = 0; b < nb; b++) begin
            beat_t e;
            e.data = 64'd0;
            e.keep = 8'd0;
            for (int l = 0; l < 8; l++) begin
                if (b * 8 + l < total) begin
                    e.data[l*8 +: 8] = stream[b * 8 + l];
                    e.keep[l] = 1'b1;
                end
            end
            e.last = (b == nb - 1);
            e.user = e.last && ((n != int'(len)) || tuser_last);
            exp_q.push_back(e);
        end
        send_header(typ, ver, epo, seq, len, exp_busy);
        for (int b = 0; b < (n + 7) / 8; b++) begin
            bit done;
            done = 0;
            s_tdata = 64'd0;
            s_tkeep = 8'd0;
            for (int l = 0; l < 8; l++) begin
                if (b * 8 + l < n) begin
                    s_tdata[l*8 +: 8] = pay[b * 8 + l];
                    s_tkeep[l] = 1'b1;
                end
            end
            s_tlast  = (b == (n + 7) / 8 - 1);
            s_tuser  = s_tlast && tuser_last;
            s_tvalid = 1'b1;
            for (int i = 0; i < 500 && !done; i++) begin
                @(negedge clk);
                if (s_tready) done = 1;
            end
            if (!done) check("payload_timeout", 64'd0, 64'd1);
            @(posedge clk);
            #1;
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        s_tuser  = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 2000 && exp_q.size() != 0; i++) @(negedge clk);
        check("drain", 64'(exp_q.size()), 64'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic fill_pay(input logic [7:0] base, input int n);
        for (int i = 0; i < n; i++) pay[i] = base + 8'(i);
    endtask

    initial begin
        int e0;
        tests = 0; fails = 0; err_cnt = 0; tl_done = 0; hdr_cnt = 0;
        rand_mode = 1'b0; tready_fixed = 1'b0; prev_hold = 1'b0;
        hdr_valid = 1'b0; hdr_type = 8'd0; hdr_version = 16'd0; hdr_epoch = 16'd0;
        hdr_seqnum = 48'd0; hdr_length = 16'd0;
        s_tdata = 64'd0; s_tkeep = 8'd0; s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = 1'b0;
        rst_n = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_hdr_ready", {63'd0, hdr_ready}, 64'd0);
        check("rst_pay_ready", {63'd0, s_tready}, 64'd0);
        check("rst_outputs", {54'd0, m_tvalid, m_tkeep, m_tlast}, 64'd0);
        check("rst_tdata", m_tdata, 64'd0);
        check("rst_busy_err", {62'd0, busy, err_pulse}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("hdr_ready_after_rst", {63'd0, hdr_ready}, 64'd1);
        tready_fixed = 1'b1;

        // Single short record
        pay[0] = 8'hAA; pay[1] = 8'hBB; pay[2] = 8'hCC;
        e0 = err_cnt;
        send_record(8'h17, 16'hFEFD, 16'h0001, 48'h5, 16'd3, 3, 1'b0, 1'b0);
        wait_drain();
        check("t1_err", 64'(err_cnt - e0), 64'd0);
        $display("[TB] record1 done");

        // Two full beats, tail of five bytes
        fill_pay(8'h00, 16);
        e0 = err_cnt;
        send_record(8'h17, 16'hFEFD, 16'h0001, 48'h6, 16'd16, 16, 1'b0, 1'b0);
        wait_drain();
        check("t2_err", 64'(err_cnt - e0), 64'd0);
        $display("[TB] record2 done");

        // Length mismatch: tuser on the last beat and one error pulse
        e0 = err_cnt;
        send_record(8'h17, 16'hFEFD, 16'h0001, 48'h7, 16'd20, 16, 1'b0, 1'b0);
        wait_drain();
        check("t3_err_pulse", 64'(err_cnt - e0), 64'd1);
        $display("[TB] record3 done");

        // Input tuser on a short last beat, length matches
        fill_pay(8'h40, 10);
        e0 = err_cnt;
        send_record(8'h16, 16'hFEFD, 16'h0002, 48'h123456789ABC, 16'd10, 10, 1'b1, 1'b0);
        wait_drain();
        check("t4_err", 64'(err_cnt - e0), 64'd0);
        $display("[TB] record4 done");

        // Random backpressure
        rand_mode = 1'b1;
        fill_pay(8'h00, 16);
        e0 = err_cnt;
        send_record(8'h17, 16'hFEFD, 16'h0001, 48'h8, 16'd16, 16, 1'b0, 1'b0);
        wait_drain();
        check("t5_err", 64'(err_cnt - e0), 64'd0);
        $display("[TB] record5 done");

        // Back-to-back records under backpressure
        fill_pay(8'h80, 12);
        e0 = err_cnt;
        send_record(8'h17, 16'hFEFD, 16'h0003, 48'h9, 16'd12, 12, 1'b0, 1'b0);
        fill_pay(8'hC0, 5);
        send_record(8'h17, 16'hFEFD, 16'h0003, 48'hA, 16'd5, 5, 1'b0, 1'b1);
        wait_drain();
        check("t6_err", 64'(err_cnt - e0), 64'd0);
        check("t6_busy_idle", {63'd0, busy}, 64'd0);
        $display("[TB] record6/7 done");

        // Reset in the middle of a record
        rand_mode = 1'b0;
        tready_fixed = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        send_header(8'h17, 16'hFEFD, 16'h0004, 48'hB, 16'd16, 1'b0);
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("midrst_tvalid", {63'd0, m_tvalid}, 64'd0);
        check("midrst_tdata", m_tdata, 64'd0);
        check("midrst_flags", {50'd0, m_tkeep, m_tlast, m_tuser, busy, err_pulse, hdr_ready, s_tready}, 64'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        hdr_cnt = tl_done;
        @(posedge clk);
        #1;
        check("hdr_ready_after_midrst", {63'd0, hdr_ready}, 64'd1);
        tready_fixed = 1'b1;
        pay[0] = 8'hAA; pay[1] = 8'hBB; pay[2] = 8'hCC;
        e0 = err_cnt;
        send_record(8'h17, 16'hFEFD, 16'h0001, 48'h5, 16'd3, 3, 1'b0, 1'b0);
        wait_drain();
        check("t8_err", 64'(err_cnt - e0), 64'd0);
        $display("[TB] record after reset done");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
